risc16_core: RTL and testbench



---
 rtl/risc16_pkg.sv | 70 +++++++
 rtl/risc16_regfile.sv | 53 +++++
 rtl/risc16_core.sv | 217 +++++++++++++++++++++
 tb/tb_risc16_core.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : risc16_pkg
//  Brief   : Shared ISA definitions and pipeline register layouts for the
//            RiSC-16 five-stage core.
//  Rev     : 1.0  initial release
// ============================================================================
package risc16_pkg;

    // Major opcode, instruction bits [15:13]
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_JALR = 3'b111
    } opcode_e;

    typedef logic [2:0] reg_idx_t;

    // Field positions (all register fields are 3 bits wide)
    localparam int OP_LSB = 13;
    localparam int RA_LSB = 10;
    localparam int RB_LSB = 7;
    localparam int RC_LSB = 0;

    // add r0,r0,r0 -- the bubble/flush instruction
    localparam logic [15:0] NOP = 16'h0000;

    // Decoded instruction travelling from ID to EX.
    // src1 is always the rB slot; src2 is rC for ADD/NAND and rA for SW/BEQ.
    // An unused source slot is forced to r0 so hazard and forwarding logic
    // can ignore it without knowing the opcode.
    typedef struct packed {
        opcode_e     op;
        reg_idx_t    dst;
        logic        wr_en;
        reg_idx_t    src1;
        reg_idx_t    src2;
        logic [15:0] val1;
        logic [15:0] val2;
        logic [15:0] imm;
        logic [15:0] pc;
    } id_ex_t;

    // Result of EX; result doubles as the data address for LW/SW
    typedef struct packed {
        logic        is_sw;
        logic        is_lw;
        logic        wr_en;
        reg_idx_t    dst;
        logic [15:0] result;
        logic [15:0] store_data;
    } ex_mem_t;

    typedef struct packed {
        logic        wr_en;
        reg_idx_t    dst;
        logic [15:0] data;
    } mem_wb_t;

    function automatic logic [15:0] sext7(input logic [6:0] imm);
        return {{9{imm[6]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/risc16_regfile.sv
`default_nettype none
// ============================================================================
//  Module  : risc16_regfile
//  Brief   : 8x16 register file, two read ports, one write port. r0 always
//            reads zero; a read of the register being written this cycle
//            returns the incoming value.
//  Rev     : 1.0  initial release
// ============================================================================
module risc16_regfile
    import risc16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  reg_idx_t    rd_addr1,
    output logic [15:0] rd_data1,
    input  reg_idx_t    rd_addr2,
    output logic [15:0] rd_data2,
    input  logic        wr_en,
    input  reg_idx_t    wr_addr,
    input  logic [15:0] wr_data
);

    logic [15:0] regs [8];

    // Register storage; writes to r0 are dropped so regs[0] stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read port 1 with write-through bypass
    always_comb begin
        rd_data1 = '0;
        if (rd_addr1 != '0) begin
            rd_data1 = (wr_en && (wr_addr == rd_addr1)) ? wr_data : regs[rd_addr1];
        end
    end

    // Read port 2 with write-through bypass
    always_comb begin
        rd_data2 = '0;
        if (rd_addr2 != '0) begin
            rd_data2 = (wr_en && (wr_addr == rd_addr2)) ? wr_data : regs[rd_addr2];
        end
    end

endmodule
`default_nettype wire

// File: rtl/risc16_core.sv
`default_nettype none
// ============================================================================
//  Module  : risc16_core
//  Brief   : Five-stage pipelined RiSC-16 core (IF/ID/EX/MEM/WB) with full
//            operand forwarding, one-cycle load-use interlock and
//            predict-not-taken control flow resolved in EX.
//  Rev     : 1.0  initial release
// ============================================================================
module risc16_core #(
    parameter logic [15:0] p_RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_inst,
    output logic [15:0] o_pc_next,
    input  logic [15:0] i_mem_rd_data,
    output logic [15:0] o_mem_wr_data,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_wr_en
);
    import risc16_pkg::*;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic [15:0] pc;
    logic [15:0] ifid_inst;
    logic [15:0] ifid_pc;
    id_ex_t      idex;
    ex_mem_t     exmem;
    mem_wb_t     memwb;

    // ------------------------------------------------------------------
    // ID stage signals
    // ------------------------------------------------------------------
    opcode_e     id_op;
    reg_idx_t    id_ra;
    reg_idx_t    id_rb;
    reg_idx_t    id_rc;
    reg_idx_t    id_src1;
    reg_idx_t    id_src2;
    logic [15:0] rf_rd1;
    logic [15:0] rf_rd2;
    id_ex_t      id_dec;
    logic        stall;

    // ------------------------------------------------------------------
    // EX stage signals
    // ------------------------------------------------------------------
    logic [15:0] ex_op1;
    logic [15:0] ex_op2;
    ex_mem_t     ex_out;
    logic        redirect;
    logic [15:0] redirect_pc;

    assign id_op = opcode_e'(ifid_inst[OP_LSB +: 3]);
    assign id_ra = ifid_inst[RA_LSB +: 3];
    assign id_rb = ifid_inst[RB_LSB +: 3];
    assign id_rc = ifid_inst[RC_LSB +: 3];

    // Map the instruction's true source registers onto the two read ports
    always_comb begin
        id_src1 = (id_op == OP_LUI) ? reg_idx_t'(0) : id_rb;
        id_src2 = '0;
        case (id_op)
            OP_ADD, OP_NAND: id_src2 = id_rc;
            OP_SW, OP_BEQ:   id_src2 = id_ra;
            default:         id_src2 = '0;
        endcase
    end

    risc16_regfile u_regfile (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .rd_addr1 (id_src1),
        .rd_data1 (rf_rd1),
        .rd_addr2 (id_src2),
        .rd_data2 (rf_rd2),
        .wr_en    (memwb.wr_en),
        .wr_addr  (memwb.dst),
        .wr_data  (memwb.data)
    );

    // Build the ID/EX payload from the instruction held in IF/ID
    always_comb begin
        id_dec       = '0;
        id_dec.op    = id_op;
        id_dec.dst   = id_ra;
        id_dec.wr_en = (id_op != OP_SW) && (id_op != OP_BEQ) && (id_ra != '0);
        id_dec.src1  = id_src1;
        id_dec.src2  = id_src2;
        id_dec.val1  = rf_rd1;
        id_dec.val2  = rf_rd2;
        id_dec.imm   = (id_op == OP_LUI) ? {ifid_inst[9:0], 6'b000000}
                                         : sext7(ifid_inst[6:0]);
        id_dec.pc    = ifid_pc;
    end

    // Load-use interlock: a LW in EX cannot forward in time to its consumer in ID
    assign stall = (idex.op == OP_LW) && idex.wr_en &&
                   (((id_src1 != '0) && (id_src1 == idex.dst)) ||
                    ((id_src2 != '0) && (id_src2 == idex.dst)));

    // Youngest producer wins; a load in EX/MEM never forwards because the
    // interlock guarantees it has reached MEM/WB before the consumer hits EX
    function automatic logic [15:0] fwd(input reg_idx_t    src,
                                        input logic [15:0] rf_val,
                                        input ex_mem_t     em,
                                        input mem_wb_t     mw);
        if ((src != '0) && em.wr_en && !em.is_lw && (em.dst == src)) begin
            return em.result;
        end else if ((src != '0) && mw.wr_en && (mw.dst == src)) begin
            return mw.data;
        end
        return rf_val;
    endfunction

    // EX operand selection through the forwarding network
    always_comb begin
        ex_op1 = fwd(idex.src1, idex.val1, exmem, memwb);
        ex_op2 = fwd(idex.src2, idex.val2, exmem, memwb);
    end

    // ALU, address generation and branch/jump resolution
    always_comb begin
        ex_out            = '0;
        ex_out.is_sw      = (idex.op == OP_SW);
        ex_out.is_lw      = (idex.op == OP_LW);
        ex_out.wr_en      = idex.wr_en;
        ex_out.dst        = idex.dst;
        ex_out.store_data = ex_op2;
        redirect          = 1'b0;
        redirect_pc       = idex.pc + 16'd1;
        case (idex.op)
            OP_ADD:  ex_out.result = ex_op1 + ex_op2;
            OP_ADDI: ex_out.result = ex_op1 + idex.imm;
            OP_NAND: ex_out.result = ~(ex_op1 & ex_op2);
            OP_LUI:  ex_out.result = idex.imm;
            OP_SW,
            OP_LW:   ex_out.result = ex_op1 + idex.imm;
            OP_BEQ: begin
                ex_out.result = ex_op1;
                redirect      = (ex_op1 == ex_op2);
                redirect_pc   = idex.pc + 16'd1 + idex.imm;
            end
            OP_JALR: begin
                ex_out.result = idex.pc + 16'd1;
                redirect      = 1'b1;
                redirect_pc   = ex_op1;
            end
            default: ex_out.result = '0;
        endcase
    end

    // Fetch PC: redirect beats stall, otherwise sequential with natural wrap
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc <= p_RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (!stall) begin
            pc <= pc + 16'd1;
        end
    end

    // IF/ID register: flushed on redirect, held during a load-use stall
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ifid_inst <= NOP;
            ifid_pc   <= '0;
        end else if (redirect) begin
            ifid_inst <= NOP;
            ifid_pc   <= '0;
        end else if (!stall) begin
            ifid_inst <= i_inst;
            ifid_pc   <= pc;
        end
    end

    // ID/EX register: bubble on redirect or stall
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idex <= '0;
        end else if (redirect || stall) begin
            idex <= '0;
        end else begin
            idex <= id_dec;
        end
    end

    // EX/MEM register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exmem <= '0;
        end else begin
            exmem <= ex_out;
        end
    end

    // MEM/WB register: loads capture RAM read data at the end of MEM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            memwb <= '0;
        end else begin
            memwb.wr_en <= exmem.wr_en;
            memwb.dst   <= exmem.dst;
            memwb.data  <= exmem.is_lw ? i_mem_rd_data : exmem.result;
        end
    end

    assign o_pc_next     = pc;
    assign o_mem_addr    = exmem.result;
    assign o_mem_wr_data = exmem.store_data;
    assign o_mem_wr_en   = exmem.is_sw;

endmodule
`default_nettype wire

// File: tb/tb_risc16_core.sv
`default_nettype none
// ============================================================================
//  Module  : tb_risc16_core
//  Brief   : Self-checking bench for risc16_core. Programs are executed on an
//            instruction-level reference model that also predicts the cycle
//            at which each store appears; the observed store stream is
//            compared against it.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_risc16_core;

    logic        clk;
    logic        rst_n;
    logic        ram_clr;
    logic [15:0] inst;
    logic [15:0] pc_next;
    logic [15:0] mem_rd_data;
    logic [15:0] mem_wr_data;
    logic [15:0] mem_addr;
    logic        mem_wr_en;

    logic [15:0] rom [256];
    logic [15:0] ram [1024];

    int checks;
    int errors;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic [31:0] cyc;
    } st_t;

    st_t exp_q[$];
    st_t obs_q[$];

    risc16_core #(.p_RESET_PC(16'h0000)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_inst        (inst),
        .o_pc_next     (pc_next),
        .i_mem_rd_data (mem_rd_data),
        .o_mem_wr_data (mem_wr_data),
        .o_mem_addr    (mem_addr),
        .o_mem_wr_en   (mem_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM and data RAM with synchronous write
    assign inst        = rom[pc_next[7:0]];
    assign mem_rd_data = ram[mem_addr[9:0]];

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
        end else if (mem_wr_en) begin
            ram[mem_addr[9:0]] <= mem_wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [6:0] imm);
        return {op, a, b, imm};
    endfunction

    function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [2:0] c);
        return {op, a, b, 4'b0000, c};
    endfunction

    function automatic logic [15:0] lui(input logic [2:0] a, input logic [9:0] imm);
        return {3'b011, a, imm};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    // Store r0..r7 to 48..55, then spin on beq r0,r0,-1; returns spin address
    task automatic put_dump(input int base, output logic [15:0] halt);
        for (int k = 0; k < 8; k++) rom[base + k] = rri(3'd4, 3'(k), 3'd0, 7'(48 + k));
        rom[base + 8] = rri(3'd6, 3'd0, 3'd0, 7'h7F);
        halt = 16'(base + 8);
    endtask

    // ---------------- reference model ----------------
    function automatic bit reads_reg(input logic [15:0] ins, input logic [2:0] x);
        logic [2:0] a, b, c;
        a = ins[12:10]; b = ins[9:7]; c = ins[2:0];
        case (ins[15:13])
            3'd0, 3'd2:       return (b == x) || (c == x);
            3'd1, 3'd5, 3'd7: return (b == x);
            3'd4, 3'd6:       return (a == x) || (b == x);
            default:          return 1'b0;
        endcase
    endfunction

    // Architectural execution; t is the cycle the instruction effectively
    // leaves IF, so its MEM cycle is t+3. Load-use costs 1, taken flow 2.
    task automatic model(input logic [15:0] halt_pc, output int tend);
        logic [15:0] r [8];
        logic [15:0] mm [int];
        logic [15:0] pc, npc, ins, s, ad, v;
        logic [2:0]  op, a, b, c;
        bit          wr;
        int          t, extra, steps;
        exp_q.delete();
        for (int i = 0; i < 8; i++) r[i] = '0;
        pc = '0; t = 0; steps = 0;
        while ((pc != halt_pc) && (steps < 4000)) begin
            ins = rom[pc[7:0]];
            op = ins[15:13]; a = ins[12:10]; b = ins[9:7]; c = ins[2:0];
            s = {{9{ins[6]}}, ins[6:0]};
            npc = pc + 16'd1; extra = 0; v = '0; wr = 1'b1;
            case (op)
                3'd0: v = r[b] + r[c];
                3'd1: v = r[b] + s;
                3'd2: v = ~(r[b] & r[c]);
                3'd3: v = {ins[9:0], 6'b000000};
                3'd4: begin
                    wr = 1'b0;
                    ad = r[b] + s;
                    mm[int'(ad[9:0])] = r[a];
                    exp_q.push_back('{addr: ad, data: r[a], cyc: 32'(t + 3)});
                end
                3'd5: begin
                    ad = r[b] + s;
                    v = mm.exists(int'(ad[9:0])) ? mm[int'(ad[9:0])] : 16'h0000;
                    if ((a != 3'd0) && reads_reg(rom[npc[7:0]], a)) extra = 1;
                end
                3'd6: begin
                    wr = 1'b0;
                    if (r[a] == r[b]) begin
                        npc = pc + 16'd1 + s;
                        extra = 2;
                    end
                end
                default: begin
                    v = pc + 16'd1;
                    npc = r[b];
                    extra = 2;
                end
            endcase
            if (wr && (a != 3'd0)) r[a] = v;
            pc = npc;
            t = t + 1 + extra;
            steps++;
        end
        tend = t;
    endtask

    // ---------------- DUT execution ----------------
    task automatic run_prog(input int ncycles);
        obs_q.delete();
        @(negedge clk);
        rst_n = 1'b0; ram_clr = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; ram_clr = 1'b0;
        for (int c = 0; c < ncycles; c++) begin
            if (mem_wr_en === 1'b1)
                obs_q.push_back('{addr: mem_addr, data: mem_wr_data, cyc: 32'(c)});
            @(negedge clk);
        end
    endtask

    task automatic run_and_compare(input string name, input logic [15:0] halt);
        int tend;
        model(halt, tend);
        run_prog(tend + 12);
        check($sformatf("%s n_stores", name), 32'(obs_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                check($sformatf("%s st%0d addr", name, i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
                check($sformatf("%s st%0d data", name, i), 32'(obs_q[i].data), 32'(exp_q[i].data));
                check($sformatf("%s st%0d cyc", name, i), obs_q[i].cyc, exp_q[i].cyc);
            end
        end
    endtask

    // Last observed value dumped for register k (X if never stored)
    function automatic logic [31:0] dump_val(input int k);
        logic [31:0] v;
        v = 'x;
        foreach (obs_q[i]) if (obs_q[i].addr == 16'(48 + k)) v = 32'(obs_q[i].data);
        return v;
    endfunction

    function automatic logic [31:0] obs_cyc(input int i);
        if (i < obs_q.size()) return obs_q[i].cyc;
        return 'x;
    endfunction

    function automatic logic [31:0] obs_data(input int i);
        if (i < obs_q.size()) return 32'(obs_q[i].data);
        return 'x;
    endfunction

    task automatic gen_random();
        logic [2:0] a, b, c;
        logic [6:0] imm;
        int         kind, lim;
        logic [15:0] halt;
        clear_rom();
        for (int pc = 0; pc < 40; pc++) begin
            kind = $urandom_range(0, 9);
            a = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            c = 3'($urandom_range(0, 7));
            imm = 7'($urandom);
            if ((kind == 6 || kind == 7) && ($urandom_range(0, 1) == 1)) begin
                b = 3'd0;
                imm = 7'($urandom_range(0, 7));
            end
            case (kind)
                0, 1: rom[pc] = rrr(3'd0, a, b, c);
                2, 3: rom[pc] = rri(3'd1, a, b, imm);
                4:    rom[pc] = rrr(3'd2, a, b, c);
                5:    rom[pc] = lui(a, 10'($urandom));
                6:    rom[pc] = rri(3'd4, a, b, imm);
                7:    rom[pc] = rri(3'd5, a, b, imm);
                8: begin
                    lim = 39 - pc;
                    if (lim > 4) lim = 4;
                    rom[pc] = rri(3'd6, a, b, 7'($urandom_range(0, lim)));
                end
                default: rom[pc] = rri(3'd1, a, 3'd0, imm);
            endcase
        end
        put_dump(40, halt);
    endtask

    initial begin
        logic [15:0] halt;
        bit          found;
        checks = 0; errors = 0;
        rst_n = 1'b0; ram_clr = 1'b1;
        clear_rom();
        repeat (2) @(negedge clk);
        check("reset_pc", 32'(pc_next), 32'h0000);
        check("reset_wr_en", 32'(mem_wr_en), 32'h0);

        // ALU chain, LUI/ADDI, r0 write, store + load-use
        clear_rom();
        rom[0] = rri(3'd1, 3'd1, 3'd0, 7'd5);
        rom[1] = rri(3'd1, 3'd2, 3'd1, 7'h7D);
        rom[2] = rrr(3'd0, 3'd3, 3'd1, 3'd2);
        rom[3] = rrr(3'd2, 3'd4, 3'd3, 3'd3);
        rom[4] = lui(3'd5, 10'h3FF);
        rom[5] = rri(3'd1, 3'd5, 3'd5, 7'h3F);
        rom[6] = rrr(3'd0, 3'd0, 3'd5, 3'd5);
        rom[7] = rri(3'd4, 3'd1, 3'd0, 7'd3);
        rom[8] = rri(3'd5, 3'd6, 3'd0, 7'd3);
        rom[9] = rrr(3'd0, 3'd7, 3'd6, 3'd6);
        put_dump(10, halt);
        run_and_compare("alu", halt);
        check("alu r0", dump_val(0), 32'h0000);
        check("alu r1", dump_val(1), 32'h0005);
        check("alu r2", dump_val(2), 32'h0002);
        check("alu r3", dump_val(3), 32'h0007);
        check("alu r4", dump_val(4), 32'hFFF8);
        check("alu r5", dump_val(5), 32'hFFFF);
        check("alu r6", dump_val(6), 32'h0005);
        check("alu r7", dump_val(7), 32'h000A);
        check("alu sw_mem3", obs_data(0), 32'h0005);
        check("alu loaduse_gap", obs_cyc(1) - obs_cyc(0), 32'd4);

        // Taken branch skips two instructions
        clear_rom();
        rom[0] = rri(3'd1, 3'd1, 3'd0, 7'd1);
        rom[1] = rri(3'd6, 3'd0, 3'd0, 7'd2);
        rom[2] = rri(3'd1, 3'd1, 3'd1, 7'd2);
        rom[3] = rri(3'd1, 3'd1, 3'd1, 7'd4);
        rom[4] = rri(3'd1, 3'd2, 3'd1, 7'd0);
        put_dump(5, halt);
        run_and_compare("beq", halt);
        check("beq r1", dump_val(1), 32'h0001);
        check("beq r2", dump_val(2), 32'h0001);
        check("beq first_store_cyc", obs_cyc(0), 32'd8);

        // JALR from PC 10 to 20
        clear_rom();
        rom[0] = rri(3'd1, 3'd2, 3'd0, 7'd20);
        rom[10] = rrr(3'd7, 3'd7, 3'd2, 3'd0);
        rom[11] = rri(3'd1, 3'd1, 3'd1, 7'd1);
        rom[12] = rri(3'd1, 3'd1, 3'd1, 7'd1);
        for (int i = 13; i < 20; i++) rom[i] = rri(3'd1, 3'd3, 3'd3, 7'd1);
        put_dump(20, halt);
        run_and_compare("jalr", halt);
        check("jalr r7", dump_val(7), 32'h000B);
        check("jalr r1", dump_val(1), 32'h0000);
        check("jalr r2", dump_val(2), 32'h0014);
        check("jalr r3", dump_val(3), 32'h0000);
        check("jalr first_store_cyc", obs_cyc(0), 32'd16);

        // Randomized programs
        for (int n = 0; n < 10; n++) begin
            gen_random();
            run_and_compare($sformatf("rnd%0d", n), 16'd48);
        end

        // Reset asserted while a store sits in MEM
        clear_rom();
        rom[0] = rri(3'd1, 3'd1, 3'd0, 7'h2A);
        rom[1] = rri(3'd4, 3'd1, 3'd0, 7'd9);
        rom[2] = rri(3'd6, 3'd0, 3'd0, 7'h7F);
        @(negedge clk);
        rst_n = 1'b0; ram_clr = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; ram_clr = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (mem_wr_en === 1'b1) found = 1'b1;
        end
        check("rst store_seen", 32'(found), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst async_pc", 32'(pc_next), 32'h0000);
        check("rst async_wr_en", 32'(mem_wr_en), 32'h0);
        @(posedge clk);
        #1;
        check("rst no_partial_write", 32'(ram[9]), 32'h0000);

        // Registers come back cleared
        clear_rom();
        put_dump(0, halt);
        run_and_compare("post_rst", halt);
        for (int k = 1; k < 8; k++) check($sformatf("post_rst r%0d", k), dump_val(k), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
